mem_sram_access: RTL
====================

Name: mem_sram_access

Overview:
- MEM-stage block that sits directly downstream of the EX store-data formatter.
- Takes the formatted address, byte strobes and write data, and runs the SRAM-like data-bus transaction (req / addr_ok / data_ok).
- Aligns and merges load data (lb/lbu/lh/lhu/lw/lwl/lwr), then hands one result per instruction to WB under a valid/allowin handshake.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- DW, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- es_valid  in  1  EX presents an instruction.
- ms_allowin  out  1  MEM accepts this cycle.
- es_mem_en  in  1  instruction accesses memory; already gated by EX exception/AdES.
- es_mem_wr  in  1  1 = store, 0 = load.
- es_addr  in  32  effective address.
- es_wstrb  in  4  store byte strobes.
- es_wdata  in  32  formatted store data.
- es_ld_type  in  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}.
- es_rt_data  in  32  old rt value, used for the lwl/lwr merge.
- es_result  in  32  ALU result for non-memory instructions.
- flush  in  1  exception/eret cancel of the MEM-stage instruction.
- data_req  out  1  bus request.
- data_wr  out  1  bus write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address.
- data_wstrb  out  4  bus strobes.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  request accepted.
- data_data_ok  in  1  response returned (loads and stores).
- data_rdata  in  32  read data.
- ms_to_ws_valid  out  1  result valid to WB.
- ws_allowin  in  1  WB accepts.
- ms_final_result  out  32  load result or pass-through value.

Behaviour:
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- Reset (resetn = 0 at a clk edge):
  - state = IDLE.
  - data_req = 0, ms_to_ws_valid = 0, ms_final_result = 0, all captured registers = 0.
  - A reset during REQ or WAIT abandons the transaction. A late data_ok arriving after reset is ignored in IDLE.
- ms_allowin = (state == IDLE) | (state == DONE & ws_allowin). It is never high in REQ, WAIT or DRAIN.
- Accept = es_valid & ms_allowin. On accept, capture all es_* inputs.
  - If es_mem_en = 1, next state is REQ.
  - Otherwise next state is DONE, with result = es_result.
- REQ:
  - data_req = 1. Bus fields come from registers and are stable until addr_ok.
  - addr_ok = 1 -> WAIT.
  - data_size: lb/lbu = 0, lh/lhu = 1, all others = 2.
  - lwl/lwr: data_addr[1:0] = 0 and data_wstrb = 0.
- WAIT: data_req = 0. data_ok = 1 -> DONE, latching the formatted result.
  - Stores: result = 0.
- DONE: ms_to_ws_valid = 1. Leave on ws_allowin, either to IDLE or directly accepting the next instruction.
- Load formatting (ea = captured addr[1:0]):
  - lb/lbu: byte ea, sign- or zero-extended.
  - lh/lhu: half ea[1], sign- or zero-extended.
  - lw: data_rdata unchanged.
  - lwl:
    - ea = 0: {rdata[7:0], rt[23:0]}.
    - ea = 1: {rdata[15:0], rt[15:0]}.
    - ea = 2: {rdata[23:0], rt[7:0]}.
    - ea = 3: rdata.
  - lwr:
    - ea = 0: rdata.
    - ea = 1: {rt[31:24], rdata[31:8]}.
    - ea = 2: {rt[31:16], rdata[31:16]}.
    - ea = 3: {rt[31:8], rdata[31:24]}.
- Flush (highest priority after reset):
  - REQ & ~addr_ok -> IDLE, data_req drops next cycle.
  - REQ & addr_ok, or WAIT & ~data_ok -> DRAIN.
  - WAIT & data_ok -> IDLE.
  - DONE -> IDLE, ms_to_ws_valid drops next cycle.
  - Flush never cancels an accept presented in the same cycle from IDLE; EX is responsible for gating that case.
- DRAIN: data_req = 0, ms_to_ws_valid = 0. data_ok = 1 -> IDLE; the returned data is discarded.
- Only one outstanding transaction at a time. A data_ok seen in IDLE, REQ or DONE is ignored.
- Base load latency: accept at edge N, data_req high at N+1. addr_ok at N+1 and data_ok at N+2 give ms_to_ws_valid high at N+3.

Optional Feature:
- MEM_REQ_FAST_EN defined:
  - In IDLE, or DONE with ws_allowin, an accept with es_mem_en drives data_req and the bus fields combinationally from es_* in the accept cycle.
  - addr_ok in that same cycle goes straight to WAIT; otherwise go to REQ.
  - Saves one cycle.
  - flush never coincides with the accept cycle; EX is responsible for guaranteeing this.
- Undefined: the request is issued from registers only, one cycle after accept, as described under Behaviour.

Test Plan:
- lw, addr 0x1000, addr_ok at the first req cycle, data_ok one cycle later, rdata 0x8899AABB -> data_size = 2, ms_final_result = 0x8899AABB, valid 3 cycles after accept (2 cycles with MEM_REQ_FAST_EN).
- lb/lbu/lh/lhu, addr 0x1003 / 0x1002, rdata 0x80FF7F01 -> lb = 0xFFFFFF80, lbu = 0x00000080, lh = 0xFFFF80FF, lhu = 0x000080FF.
- lwl at ea = 1 and lwr at ea = 2, rt = 0x11223344, rdata = 0xAABBCCDD -> data_addr aligned, lwl = 0xCCDD3344, lwr = 0x1122AABB.
- sw with addr_ok held low 4 cycles -> data_req, data_addr and data_wstrb stable throughout; ms_allowin stays low until data_ok; result valid, then a new accept occurs on the DONE & ws_allowin cycle.
- flush in WAIT, data_ok 2 cycles later with rdata 0xDEADBEEF -> DRAIN, no ms_to_ws_valid, then back to IDLE; the next lw returns its own data.
- resetn low during WAIT -> IDLE, all outputs 0; a stray data_ok the following cycle produces no valid.

Source files
------------

// File: rtl/mem_sram_access.sv
// MEM-stage SRAM-like data-bus access: issues one req/addr_ok/data_ok transaction per
// memory instruction, formats load data, and hands one result per instruction to WB.
// Optional: define MEM_REQ_FAST_EN to issue the request combinationally in the accept cycle.
module mem_sram_access #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          es_valid,
    output logic          ms_allowin,
    input  logic          es_mem_en,
    input  logic          es_mem_wr,
    input  logic [DW-1:0] es_addr,
    input  logic [3:0]    es_wstrb,
    input  logic [DW-1:0] es_wdata,
    input  logic [6:0]    es_ld_type,
    input  logic [DW-1:0] es_rt_data,
    input  logic [DW-1:0] es_result,
    input  logic          flush,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [DW-1:0] data_addr,
    output logic [3:0]    data_wstrb,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic          ms_to_ws_valid,
    input  logic          ws_allowin,
    output logic [DW-1:0] ms_final_result
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

    state_e        state_q, state_d;
    logic          mem_wr_q;
    logic [DW-1:0] addr_q;
    logic [3:0]    wstrb_q;
    logic [DW-1:0] wdata_q;
    logic [6:0]    ld_type_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] result_q, result_d;

    logic          accept;
    logic          capture;
    logic          fast_req;

    assign ms_allowin     = (state_q == S_IDLE) | ((state_q == S_DONE) & ws_allowin);
    assign accept         = es_valid & ms_allowin;
    assign ms_to_ws_valid = (state_q == S_DONE);
    assign ms_final_result = result_q;

`ifdef MEM_REQ_FAST_EN
    assign fast_req = accept & es_mem_en;
`else
    assign fast_req = 1'b0;
`endif

    // Bus field source: captured registers, or live EX inputs on a fast request
    logic          bus_wr;
    logic [DW-1:0] bus_addr;
    logic [3:0]    bus_wstrb;
    logic [DW-1:0] bus_wdata;
    logic [1:0]    bus_size;
    logic          bus_unal;

    always_comb begin
        bus_wr    = mem_wr_q;
        bus_addr  = addr_q;
        bus_wstrb = wstrb_q;
        bus_wdata = wdata_q;
        bus_unal  = ld_type_q[5] | ld_type_q[6];
        bus_size  = (ld_type_q[0] | ld_type_q[1]) ? 2'd0 :
                    (ld_type_q[2] | ld_type_q[3]) ? 2'd1 : 2'd2;
`ifdef MEM_REQ_FAST_EN
        if (fast_req) begin
            bus_wr    = es_mem_wr;
            bus_addr  = es_addr;
            bus_wstrb = es_wstrb;
            bus_wdata = es_wdata;
            bus_unal  = es_ld_type[5] | es_ld_type[6];
            bus_size  = (es_ld_type[0] | es_ld_type[1]) ? 2'd0 :
                        (es_ld_type[2] | es_ld_type[3]) ? 2'd1 : 2'd2;
        end
`endif
    end

    assign data_req   = (state_q == S_REQ) | fast_req;
    assign data_wr    = bus_wr;
    assign data_size  = bus_size;
    assign data_wdata = bus_wdata;
    // lwl/lwr fetch the whole aligned word and merge with rt afterwards
    assign data_addr  = bus_unal ? {bus_addr[DW-1:2], 2'b00} : bus_addr;
    assign data_wstrb = bus_unal ? 4'b0000 : bus_wstrb;

    logic [1:0]    ea;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [DW-1:0] lwl_val, lwr_val, ld_fmt;

    always_comb begin
        ea    = addr_q[1:0];
        rhalf = ea[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (ea)
            2'd0: begin
                rbyte   = data_rdata[7:0];
                lwl_val = {data_rdata[7:0], rt_q[23:0]};
                lwr_val = data_rdata;
            end
            2'd1: begin
                rbyte   = data_rdata[15:8];
                lwl_val = {data_rdata[15:0], rt_q[15:0]};
                lwr_val = {rt_q[31:24], data_rdata[31:8]};
            end
            2'd2: begin
                rbyte   = data_rdata[23:16];
                lwl_val = {data_rdata[23:0], rt_q[7:0]};
                lwr_val = {rt_q[31:16], data_rdata[31:16]};
            end
            default: begin
                rbyte   = data_rdata[31:24];
                lwl_val = data_rdata;
                lwr_val = {rt_q[31:8], data_rdata[31:24]};
            end
        endcase
        ld_fmt = '0;
        if (!mem_wr_q) begin
            if (ld_type_q[0])      ld_fmt = {{24{rbyte[7]}}, rbyte};
            else if (ld_type_q[1]) ld_fmt = {24'd0, rbyte};
            else if (ld_type_q[2]) ld_fmt = {{16{rhalf[15]}}, rhalf};
            else if (ld_type_q[3]) ld_fmt = {16'd0, rhalf};
            else if (ld_type_q[4]) ld_fmt = data_rdata;
            else if (ld_type_q[5]) ld_fmt = lwl_val;
            else if (ld_type_q[6]) ld_fmt = lwr_val;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        capture  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // flush is only honoured in DONE; an IDLE accept is never cancelled
                if (state_q == S_DONE && flush) begin
                    state_d = S_IDLE;
                end else if (ms_allowin) begin
                    state_d = S_IDLE;
                    if (accept) begin
                        capture = 1'b1;
                        if (es_mem_en) begin
                            state_d = (fast_req && data_addr_ok) ? S_WAIT : S_REQ;
                        end else begin
                            state_d  = S_DONE;
                            result_d = es_result;
                        end
                    end
                end
            end
            S_REQ: begin
                if (flush)             state_d = data_addr_ok ? S_DRAIN : S_IDLE;
                else if (data_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DONE;
                        result_d = ld_fmt;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (data_data_ok) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            mem_wr_q  <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            ld_type_q <= '0;
            rt_q      <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (capture) begin
                mem_wr_q  <= es_mem_wr;
                addr_q    <= es_addr;
                wstrb_q   <= es_wstrb;
                wdata_q   <= es_wdata;
                ld_type_q <= es_ld_type;
                rt_q      <= es_rt_data;
            end
        end
    end

endmodule
